// File: rtl/maze_step_ctrl.sv
// Depth-first maze search controller: probes neighbours through the external
// next-position stage, marks visited cells in maze RAM and backtracks via an internal stack.
module maze_step_ctrl #(
  parameter int W        = 4,
  parameter int DEPTH    = 64,
  parameter int GOAL_ROW = 15,
  parameter int GOAL_COL = 15,
  localparam int SPW     = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   row,
  output logic [W-1:0]   colomn,
  output logic [1:0]     temp,
  output logic           return_ornot,
  input  logic [W-1:0]   u_row,
  input  logic [W-1:0]   u_colomn,
  input  logic           blocked,
  output logic [W-1:0]   mem_row,
  output logic [W-1:0]   mem_col,
  output logic           mem_we,
  input  logic           dout,
  output logic           busy,
  output logic           done,
  output logic           fail,
  output logic [SPW-1:0] sp
);

  localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [W-1:0]   GOAL_R  = W'(GOAL_ROW);
  localparam logic [W-1:0]   GOAL_C  = W'(GOAL_COL);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_PROBE, S_READ, S_EVAL, S_NEXTD, S_BACK, S_DONE, S_FAIL
  } state_t;

  state_t state, state_nxt;

  logic             at_edge, stack_full, stack_empty, cand_goal, push, pop;
  logic [AW-1:0]    push_idx, pop_idx;
  logic [SPW-1:0]   sp_dec;
  logic [2*W+1:0]   stack [DEPTH];
  logic [2*W+1:0]   top;
  logic             unused_blocked;

  // The next-position stage computes its own blocked flag; the edge check here supersedes it.
  assign unused_blocked = blocked;

  // mem_row/mem_col double as the candidate cell between PROBE and EVAL.
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign cand_goal   = (mem_row == GOAL_R) && (mem_col == GOAL_C);
  assign push        = (state == S_EVAL) && !dout && !stack_full;
  assign pop         = (state == S_BACK) && !stack_empty;
  assign sp_dec      = sp - SPW'(1);
  assign push_idx    = sp[AW-1:0];
  assign pop_idx     = sp_dec[AW-1:0];
  assign top         = stack[pop_idx];

  always_comb begin
    at_edge = 1'b0;
    unique case (temp)
      2'd0: at_edge = (colomn == '1);
      2'd1: at_edge = (row == '1);
      2'd2: at_edge = (row == '0);
      2'd3: at_edge = (colomn == '0);
      default: at_edge = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_FAIL: if (start) state_nxt = S_INIT;
      S_INIT:  state_nxt = (GOAL_R == '0 && GOAL_C == '0) ? S_DONE : S_PROBE;
      S_PROBE: state_nxt = at_edge ? S_NEXTD : S_READ;
      S_READ:  state_nxt = S_EVAL;
      S_EVAL: begin
        if (dout)            state_nxt = S_NEXTD;
        else if (stack_full) state_nxt = S_FAIL;
        else if (cand_goal)  state_nxt = S_DONE;
        else                 state_nxt = S_PROBE;
      end
      S_NEXTD: state_nxt = (temp == 2'd3) ? S_BACK : S_PROBE;
      S_BACK:  state_nxt = stack_empty ? S_FAIL : S_NEXTD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    return_ornot = 1'b0;
    mem_we       = 1'b0;
    done         = 1'b0;
    fail         = 1'b0;
    unique case (state)
      S_IDLE:  ;
      S_DONE:  done = 1'b1;
      S_FAIL:  fail = 1'b1;
      S_INIT: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      S_EVAL: begin
        busy   = 1'b1;
        mem_we = push;
      end
      S_BACK: begin
        busy         = 1'b1;
        return_ornot = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      colomn  <= '0;
      temp    <= '0;
      mem_row <= '0;
      mem_col <= '0;
      sp      <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            row     <= '0;
            colomn  <= '0;
            temp    <= '0;
            mem_row <= '0;
            mem_col <= '0;
            sp      <= '0;
          end
        end
        S_PROBE: begin
          if (!at_edge) begin
            mem_row <= u_row;
            mem_col <= u_colomn;
          end
        end
        S_EVAL: begin
          if (push) begin
            sp     <= sp + SPW'(1);
            row    <= mem_row;
            colomn <= mem_col;
            temp   <= '0;
          end
        end
        S_NEXTD: if (temp != 2'd3) temp <= temp + 2'd1;
        S_BACK: begin
          if (pop) begin
            {row, colomn, temp} <= top;
            sp                  <= sp_dec;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: stack storage has no reset; sp alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= {row, colomn, temp};
  end

endmodule

// File: tb/tb_maze_step_ctrl.sv
// Randomized and directed bench for maze_step_ctrl: three instances (default, goal at origin,
// two-entry stack) driven against a plain depth-first-search reference model.
module tb_maze_step_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v [3];
  logic        load_v  [3];
  logic        maze_img [16][16];

  logic        done_a [3], fail_a [3], busy_a [3], ret_a [3];
  logic [6:0]  sp_a [3];
  logic [3:0]  row_a [3], col_a [3];
  logic [7:0]  maddr_a [3];
  logic [31:0] outs_a [3];
  int          wr_cnt_a [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DEP = (g == 2) ? 2 : 64;
    localparam int GR  = (g == 1) ? 0 : 15;
    localparam int GC  = (g == 1) ? 0 : 15;
    localparam int SPW = $clog2(DEP + 1);

    logic [3:0]     row, colomn, u_row, u_colomn, mem_row, mem_col;
    logic [1:0]     temp;
    logic           return_ornot, mem_we, dout, busy, done, fail, blocked;
    logic [SPW-1:0] sp;
    logic           ram [16][16];
    logic [7:0]     wr_log [1024];
    int             wr_cnt;

    maze_step_ctrl #(.W(4), .DEPTH(DEP), .GOAL_ROW(GR), .GOAL_COL(GC)) dut (
      .clk(clk), .rst(rst), .start(start_v[g]),
      .row(row), .colomn(colomn), .temp(temp), .return_ornot(return_ornot),
      .u_row(u_row), .u_colomn(u_colomn), .blocked(blocked),
      .mem_row(mem_row), .mem_col(mem_col), .mem_we(mem_we), .dout(dout),
      .busy(busy), .done(done), .fail(fail), .sp(sp)
    );

    // Next-position stage: plain 4-bit neighbour arithmetic.
    always_comb begin
      u_row    = row;
      u_colomn = colomn;
      blocked  = 1'b0;
      case (temp)
        2'd0: begin u_colomn = colomn + 4'd1; blocked = (colomn == 4'd15); end
        2'd1: begin u_row    = row + 4'd1;    blocked = (row == 4'd15);    end
        2'd2: begin u_row    = row - 4'd1;    blocked = (row == 4'd0);     end
        default: begin u_colomn = colomn - 4'd1; blocked = (colomn == 4'd0); end
      endcase
    end

    // Maze RAM with one-cycle read latency plus a log of every write.
    always @(posedge clk) begin
      if (load_v[g]) begin
        ram    <= maze_img;
        wr_cnt <= 0;
      end else if (mem_we) begin
        ram[mem_row][mem_col] <= 1'b1;
        if (wr_cnt < 1024) wr_log[wr_cnt] <= {mem_row, mem_col};
        wr_cnt <= wr_cnt + 1;
      end
      dout <= ram[mem_row][mem_col];
    end

    assign done_a[g]   = done;
    assign fail_a[g]   = fail;
    assign busy_a[g]   = busy;
    assign ret_a[g]    = return_ornot;
    assign sp_a[g]     = 7'(sp);
    assign row_a[g]    = row;
    assign col_a[g]    = colomn;
    assign maddr_a[g]  = {mem_row, mem_col};
    assign wr_cnt_a[g] = wr_cnt;
    assign outs_a[g]   = 32'({row, colomn, temp, return_ornot, mem_row, mem_col, mem_we,
                              busy, done, fail, sp});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: depth-first search stated directly from the search rules.
  int  m_cyc, m_backs, m_sp, m_r, m_c;
  bit  m_done;
  int  m_wr [$];

  task automatic model(input int depth, input int gr, input int gc);
    bit vis [16][16];
    int st_r [$], st_c [$], st_d [$];
    int r, c, d, nr, nc;
    bit fin;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) vis[i][j] = maze_img[i][j];
    m_wr.delete();
    m_cyc = 1; m_backs = 0; m_done = 0;
    r = 0; c = 0; d = 0;
    vis[0][0] = 1'b1;
    m_wr.push_back(0);
    fin = (gr == 0 && gc == 0);
    m_done = fin;
    while (!fin) begin
      if (d == 4) begin
        m_backs++; m_cyc++;
        if (st_r.size() == 0) fin = 1;
        else begin
          r = st_r.pop_back(); c = st_c.pop_back(); d = st_d.pop_back() + 1;
          m_cyc++;
        end
      end else begin
        nr = r; nc = c;
        case (d)
          0: nc = c + 1;
          1: nr = r + 1;
          2: nr = r - 1;
          default: nc = c - 1;
        endcase
        m_cyc++;
        if (nr < 0 || nr > 15 || nc < 0 || nc > 15) begin
          m_cyc++; d++;
        end else begin
          m_cyc += 2;
          if (vis[nr][nc]) begin
            m_cyc++; d++;
          end else if (st_r.size() == depth) begin
            fin = 1;
          end else begin
            st_r.push_back(r); st_c.push_back(c); st_d.push_back(d);
            r = nr; c = nc; vis[r][c] = 1'b1;
            m_wr.push_back(r * 16 + c);
            if (r == gr && c == gc) begin m_done = 1; fin = 1; end
            d = 0;
          end
        end
      end
    end
    m_sp = st_r.size(); m_r = r; m_c = c;
  endtask

  task automatic load_maze(input int g);
    @(negedge clk); load_v[g] = 1'b1;
    @(negedge clk); load_v[g] = 1'b0;
  endtask

  task automatic run_case(input string name, input int g, input int depth,
                          input int gr, input int gc, input bit poke);
    int cyc, backs, bad;
    load_maze(g);
    model(depth, gr, gc);
    start_v[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[g] = 1'b0;
    check({name, "_start"}, {done_a[g], fail_a[g], busy_a[g], sp_a[g]}, {3'b001, 7'd0});
    cyc = 0; backs = 0;
    while (!(done_a[g] || fail_a[g]) && cyc < 10000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (ret_a[g]) backs++;
      start_v[g] = poke && cyc == 6 && !done_a[g] && !fail_a[g];
    end
    start_v[g] = 1'b0;
    check({name, "_term"}, 32'(cyc < 10000), 1);
    check({name, "_cycles"}, cyc, m_cyc);
    check({name, "_done_fail"}, {done_a[g], fail_a[g]}, {m_done, !m_done});
    check({name, "_sp"}, sp_a[g], m_sp);
    check({name, "_pos"}, {row_a[g], col_a[g]}, {4'(m_r), 4'(m_c)});
    check({name, "_writes"}, wr_cnt_a[g], m_wr.size());
    check({name, "_backs"}, backs, m_backs);
    if (g == 0) begin
      bad = -1;
      for (int i = 0; i < m_wr.size() && i < 1024; i++)
        if (bad < 0 && g_dut[0].wr_log[i] !== 8'(m_wr[i])) bad = i;
      check({name, "_wrseq"}, bad, -1);
    end
    repeat (3) @(negedge clk);
    check({name, "_hold"}, {done_a[g], fail_a[g], busy_a[g]}, {m_done, !m_done, 1'b0});
  endtask

  task automatic clear_maze();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) maze_img[i][j] = 1'b0;
  endtask

  initial begin
    int wc, dens;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin start_v[g] = 1'b0; load_v[g] = 1'b0; end
    clear_maze();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("reset_outs%0d", g), outs_a[g], 0);

    // T1: open maze, straight run along row 0 then down column 15.
    run_case("t1", 0, 64, 15, 15, 1'b1);
    check("t1_sp30", sp_a[0], 30);
    check("t1_move_writes", wr_cnt_a[0] - 1, 30);

    // T2: both interior neighbours of the origin walled.
    clear_maze();
    maze_img[0][1] = 1'b1; maze_img[1][0] = 1'b1;
    run_case("t2", 0, 64, 15, 15, 1'b0);
    check("t2_fail", {fail_a[0], sp_a[0]}, {1'b1, 7'd0});

    // T3: dead-end corridor along row 0 forces backtracking to the origin.
    clear_maze();
    maze_img[0][4] = 1'b1;
    for (int j = 1; j <= 3; j++) maze_img[1][j] = 1'b1;
    run_case("t3", 0, 64, 15, 15, 1'b0);
    check("t3_done", done_a[0], 1);
    for (int j = 1; j <= 3; j++)
      check($sformatf("t3_mark%0d", j), g_dut[0].ram[0][j], 1);

    // T4: goal at the origin; T5: two-entry stack overflows on the third push.
    clear_maze();
    run_case("t4", 1, 64, 0, 0, 1'b0);
    run_case("t5", 2, 2, 15, 15, 1'b0);
    check("t5_ovf", {fail_a[2], sp_a[2]}, {1'b1, 7'd2});
    run_case("t4_again", 1, 64, 0, 0, 1'b0);

    // T6: reset while the first probe is in READ.
    clear_maze();
    load_maze(0);
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t6_read_addr", maddr_a[0], 8'h01);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_outs_zero", outs_a[0], 0);
    wc = wr_cnt_a[0];
    check("t6_init_write_only", wc, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_idle", outs_a[0], 0);
    check("t6_no_write", wr_cnt_a[0], wc);
    run_case("t6_t1", 0, 64, 15, 15, 1'b0);

    // Random mazes of varying wall density.
    for (int k = 0; k < 10; k++) begin
      dens = $urandom_range(45, 10);
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) maze_img[i][j] = ($urandom_range(99, 0) < dens);
      run_case($sformatf("rnd%0d", k), 0, 64, 15, 15, k[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
